// File: rtl/i2c_tgt_ll.sv
// Low-level I2C target engine: START/STOP detection, 7-bit address match,
// byte shifting with single-byte rx/tx handshakes and SCL stretching on reads.
module i2c_tgt_ll #(
  parameter logic [6:0]  TGT_ADDR = 7'h50,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det
);

  localparam logic [3:0] FiltMax = 4'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdLoad, StRdData, StRdAck, StWaitStop
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rx_first_q, rx_first_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       nack_det_q, nack_det_d;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  // Glitch filters: a level flips only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= 4'd0;
      sda_cnt_q <= 4'd0;
    end else begin
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= 4'd0;
      end else if (scl_cnt_q == FiltMax) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= 4'd0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 4'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= 4'd0;
      end else if (sda_cnt_q == FiltMax) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= 4'd0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 4'd1;
      end
    end
  end

  // Previous filtered levels for edge and bus-condition detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign scl_rise = scl_f_q & ~scl_prev_q;
  assign scl_fall = ~scl_f_q & scl_prev_q;
  assign start_ev = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

  // Protocol state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_first_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      nack_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_first_q  <= rx_first_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      nack_det_q  <= nack_det_d;
    end
  end

  // Next-state logic; START/STOP override every state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rx_first_d  = rx_first_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    nack_det_d  = 1'b0;
    tx_ready    = 1'b0;
    scl_oe      = 1'b0;

    if (start_ev) begin
      state_d     = StAddr;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 4'd0;
      phase_d     = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = StIdle;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      phase_d    = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (shift_q[6:0] == TGT_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
                rw_d    = sda_f_q;
                first_d = 1'b1;
                phase_d = 1'b0;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          // First fall starts the ACK bit, second fall ends it.
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = (state_q == StAddrAck && rw_q) ? StRdLoad : StWrData;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = {shift_q[6:0], sda_f_q};
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              phase_d    = 1'b0;
              state_d    = StWrAck;
            end
          end
        end
        StRdLoad: begin
          // SCL is low here; hold it low until fabric supplies a byte.
          if (tx_valid) begin
            tx_ready   = 1'b1;
            tx_shift_d = tx_data;
            sda_oe_d   = ~tx_data[7];
            bit_cnt_d  = 4'd1;
            state_d    = StRdData;
          end else begin
            scl_oe = 1'b1;
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              phase_d   = 1'b0;
              state_d   = StRdAck;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              phase_d = 1'b1;
            end else begin
              nack_det_d = 1'b1;
              busy_d     = 1'b0;
              sda_oe_d   = 1'b0;
              state_d    = StWaitStop;
            end
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            state_d = StRdLoad;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_first  = rx_first_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign nack_det  = nack_det_q;

endmodule

// File: tb/tb_i2c_tgt_ll.sv
// Directed bench for i2c_tgt_ll: a bus host model drives SCL/SDA, fabric side
// supplies read bytes from a table, monitors log rx bytes and event pulses.
module tb_i2c_tgt_ll;

  localparam int Q = 10;
  localparam int FiltLen = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_scl, host_sda;
  logic       scl_i, sda_i;
  logic       scl_oe, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       busy, start_det, stop_det, nack_det;

  int n_checks = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_nack = 0;
  int tx_idx = 0;
  int tx_loaded = 0;
  logic [7:0] tx_mem [8];
  logic [8:0] rx_q [$];

  always #5 clk = ~clk;

  // SDA is wired-AND; the host model honours stretching explicitly.
  assign scl_i    = host_scl;
  assign sda_i    = host_sda & ~sda_oe;
  assign tx_valid = (tx_idx < tx_loaded);
  assign tx_data  = tx_mem[tx_idx[2:0]];

  i2c_tgt_ll #(
    .TGT_ADDR (7'h50),
    .FILT_LEN (FiltLen)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det),
    .nack_det  (nack_det)
  );

  // Fabric side consumes one table entry per handshake.
  always @(posedge clk) if (tx_valid && tx_ready) tx_idx <= tx_idx + 1;

  // Log received bytes and count event pulses.
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back({rx_first, rx_data});
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (nack_det) n_nack++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise SCL once the target stops stretching (bounded).
  task automatic scl_high();
    int k = 0;
    while (scl_oe && k < 2000) begin
      wait_clks(1);
      k++;
    end
    check_eq("scl_released", 32'(scl_oe), 0);
    host_scl = 1'b1;
  endtask

  task automatic host_bit(input logic b, input bit glitch, output logic o);
    wait_clks(Q);
    host_sda = b;
    wait_clks(Q);
    scl_high();
    wait_clks(Q / 2);
    if (glitch) begin
      host_scl = 1'b0;
      wait_clks(1);
      host_scl = 1'b1;
      wait_clks(Q / 2 - 1);
    end else begin
      wait_clks(Q / 2);
    end
    o = sda_i;
    wait_clks(Q);
    host_scl = 1'b0;
  endtask

  task automatic host_start();
    host_sda = 1'b0;
    wait_clks(Q);
    host_scl = 1'b0;
  endtask

  task automatic host_rstart();
    wait_clks(Q);
    host_sda = 1'b1;
    wait_clks(Q);
    host_scl = 1'b1;
    wait_clks(Q);
    host_sda = 1'b0;
    wait_clks(Q);
    host_scl = 1'b0;
  endtask

  task automatic host_stop();
    wait_clks(Q);
    host_sda = 1'b0;
    wait_clks(Q);
    host_scl = 1'b1;
    wait_clks(Q);
    host_sda = 1'b1;
    wait_clks(Q);
  endtask

  // Writes a byte (optional glitch mask per bit); returns the 9th-bit level.
  task automatic host_wr(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      host_bit(d[i], gmask[i], o);
      check_eq("wr_bit_line", 32'(o), 32'(d[i]));
    end
    host_bit(1'b1, 1'b0, ack);
  endtask

  task automatic host_rd(input logic nack, output logic [7:0] d);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      host_bit(1'b1, 1'b0, o);
      d[i] = o;
    end
    host_bit(nack, 1'b0, o);
    check_eq("rd_ack_line", 32'(o), 32'(nack));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base, s0, p0, a0, k, bad;

    tx_mem[0] = 8'hC3;
    tx_mem[1] = 8'h5A;
    tx_mem[2] = 8'h96;
    tx_mem[3] = 8'h00;
    for (int i = 4; i < 8; i++) tx_mem[i] = 8'hFF;
    host_scl = 1'b1;
    host_sda = 1'b1;
    rst = 1'b1;
    wait_clks(3);
    check_eq("rst_scl_oe", 32'(scl_oe), 0);
    check_eq("rst_sda_oe", 32'(sda_oe), 0);
    check_eq("rst_rx", {22'd0, rx_first, rx_valid, rx_data}, 0);
    check_eq("rst_tx_ready", 32'(tx_ready), 0);
    check_eq("rst_flags", {28'd0, busy, start_det, stop_det, nack_det}, 0);
    rst = 1'b0;
    wait_clks(5);
    check_eq("idle_scl_oe", 32'(scl_oe), 0);

    // Write: 0xA0, 0x12, 0x34.
    base = rx_q.size(); s0 = n_start; p0 = n_stop;
    host_start();
    host_wr(8'hA0, 8'h00, ack);
    check_eq("wr_addr_ack", 32'(ack), 0);
    check_eq("wr_busy", 32'(busy), 1);
    host_wr(8'h12, 8'h00, ack);
    check_eq("wr_d0_ack", 32'(ack), 0);
    host_wr(8'h34, 8'h00, ack);
    check_eq("wr_d1_ack", 32'(ack), 0);
    host_stop();
    wait_clks(10);
    check_eq("wr_rx_count", rx_q.size() - base, 2);
    check_eq("wr_rx0", 32'(rx_q[base]), 32'h112);
    check_eq("wr_rx1", 32'(rx_q[base + 1]), 32'h034);
    check_eq("wr_start_cnt", n_start - s0, 1);
    check_eq("wr_stop_cnt", n_stop - p0, 1);
    check_eq("wr_busy_after", 32'(busy), 0);

    // Address mismatch, then a matching repeated START.
    base = rx_q.size();
    host_start();
    host_wr(8'hA2, 8'h00, ack);
    check_eq("mm_nack", 32'(ack), 1);
    check_eq("mm_busy", 32'(busy), 0);
    host_rstart();
    host_wr(8'hA0, 8'h00, ack);
    check_eq("mm_retry_ack", 32'(ack), 0);
    host_stop();
    wait_clks(10);
    check_eq("mm_rx_count", rx_q.size() - base, 0);

    // Read with stretch.
    a0 = n_nack;
    host_start();
    host_wr(8'hA1, 8'h00, ack);
    check_eq("rd_addr_ack", 32'(ack), 0);
    wait_clks(10);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!scl_oe) bad++;
      wait_clks(1);
    end
    check_eq("rd_stretch_held", bad, 0);
    tx_loaded = 1;
    #1;
    check_eq("rd_tx_ready", 32'(tx_ready), 1);
    check_eq("rd_stretch_rel", 32'(scl_oe), 0);
    tx_loaded = 2;
    host_rd(1'b0, d);
    check_eq("rd_byte0", 32'(d), 32'hC3);
    host_rd(1'b1, d);
    check_eq("rd_byte1", 32'(d), 32'h5A);
    check_eq("rd_nack_cnt", n_nack - a0, 1);
    check_eq("rd_sda_rel", 32'(sda_oe), 0);
    check_eq("rd_busy", 32'(busy), 0);
    check_eq("rd_tx_consumed", tx_idx, 2);
    host_stop();

    // Write then repeated START into a read.
    s0 = n_start; tx_loaded = 3;
    host_start();
    host_wr(8'hA0, 8'h00, ack);
    host_wr(8'h0F, 8'h00, ack);
    check_eq("sr_wr_ack", 32'(ack), 0);
    check_eq("sr_rx", 32'(rx_q[rx_q.size() - 1]), 32'h10F);
    host_rstart();
    host_wr(8'hA1, 8'h00, ack);
    check_eq("sr_rd_addr_ack", 32'(ack), 0);
    host_rd(1'b1, d);
    check_eq("sr_rd_byte", 32'(d), 32'h96);
    host_stop();
    check_eq("sr_start_cnt", n_start - s0, 2);

    // Repeated START after four data bits.
    base = rx_q.size();
    host_start();
    host_wr(8'hA0, 8'h00, ack);
    for (int i = 0; i < 4; i++) host_bit(i[0], 1'b0, ack);
    host_rstart();
    wait_clks(10);
    check_eq("abort_sda_rel", 32'(sda_oe), 0);
    host_wr(8'hA0, 8'h00, ack);
    check_eq("abort_addr_ack", 32'(ack), 0);
    host_wr(8'h55, 8'h00, ack);
    host_stop();
    wait_clks(5);
    check_eq("abort_rx_count", rx_q.size() - base, 1);
    check_eq("abort_rx", 32'(rx_q[rx_q.size() - 1]), 32'h155);

    // One-cycle SCL glitches during data must not add bits.
    base = rx_q.size();
    host_start();
    host_wr(8'hA0, 8'h00, ack);
    host_wr(8'h3C, 8'b0010_0100, ack);
    check_eq("glitch_ack", 32'(ack), 0);
    host_stop();
    wait_clks(5);
    check_eq("glitch_rx_count", rx_q.size() - base, 1);
    check_eq("glitch_rx", 32'(rx_q[rx_q.size() - 1]), 32'h13C);

    // STOP while stretching.
    p0 = n_stop;
    host_start();
    host_wr(8'hA1, 8'h00, ack);
    wait_clks(10);
    check_eq("ss_stretching", 32'(scl_oe), 1);
    wait_clks(Q);
    host_sda = 1'b0;
    wait_clks(Q);
    host_scl = 1'b1;
    wait_clks(Q);
    host_sda = 1'b1;
    k = 0;
    while (scl_oe && k < 20) begin
      wait_clks(1);
      k++;
    end
    check_eq("ss_released", 32'(scl_oe), 0);
    check_eq("ss_latency_ok", 32'(k <= FiltLen + 3), 1);
    wait_clks(3);
    check_eq("ss_stop_cnt", n_stop - p0, 1);
    wait_clks(Q);

    // Asynchronous reset while driving SDA low on a read.
    tx_loaded = 4;
    host_start();
    host_wr(8'hA1, 8'h00, ack);
    k = 0;
    while (!sda_oe && k < 30) begin
      wait_clks(1);
      k++;
    end
    check_eq("ar_driving", 32'(sda_oe), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_sda_oe", 32'(sda_oe), 0);
    check_eq("ar_scl_oe", 32'(scl_oe), 0);
    check_eq("ar_busy", 32'(busy), 0);
    host_scl = 1'b1;
    host_sda = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
